// File: rtl/axi_lite_tc_pkg.sv
// rtl/axi_lite_tc_pkg.sv - shared types, response codes and data pattern for the AXI-Lite traffic checker
package axi_lite_tc_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ADDR_DATA,
        S_WR_RESP,
        S_RD_ADDR,
        S_RD_DATA,
        S_DRAIN,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        MODE_INCR   = 2'b00,
        MODE_INV    = 2'b01,
        MODE_WALK   = 2'b10,
        MODE_WRONLY = 2'b11
    } mode_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Computed at 64 bits; callers truncate to their data width, which gives modulo wrap.
    function automatic logic [63:0] pattern(input mode_e mode, input logic [63:0] seed,
                                            input int unsigned idx, input int unsigned dw);
        logic [63:0] sum;
        int unsigned pos;
        sum = seed + 64'(idx);
        pos = ((idx % dw) + (32'(seed[5:0]) % dw)) % dw;
        case (mode)
            MODE_INV:  pattern = ~sum;
            MODE_WALK: pattern = 64'd1 << pos;
            default:   pattern = sum;
        endcase
    endfunction

endpackage

// File: rtl/axi_lite_tc_watchdog.sv
// rtl/axi_lite_tc_watchdog.sv - handshake watchdog: counts waiting cycles, flags expiry at TIMEOUT
module axi_lite_tc_watchdog #(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!enable || clear) begin
            cnt_d = '0;
        end else if (cnt_q != LAST) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // A cycle with a handshake never counts as the expiring one.
    assign expired = enable && !clear && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/axi_lite_traffic_checker.sv
// rtl/axi_lite_traffic_checker.sv - AXI4-Lite master that writes a pattern block, reads it back and checks it
module axi_lite_traffic_checker
    import axi_lite_tc_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_TXN    = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter int TIMEOUT    = 256,
    parameter int ERR_W      = 8
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic                      INIT_AXI_TXN,
    input  logic [1:0]                MODE,
    input  logic [DATA_WIDTH-1:0]     SEED,
    output logic                      TXN_DONE,
    output logic                      ERROR,
    output logic [ERR_W-1:0]          ERR_CNT,
    output logic                      BUSY,
    output logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                M_AXI_AWPROT,
    output logic                      M_AXI_AWVALID,
    input  logic                      M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                      M_AXI_WVALID,
    input  logic                      M_AXI_WREADY,
    input  logic [1:0]                M_AXI_BRESP,
    input  logic                      M_AXI_BVALID,
    output logic                      M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                M_AXI_ARPROT,
    output logic                      M_AXI_ARVALID,
    input  logic                      M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                M_AXI_RRESP,
    input  logic                      M_AXI_RVALID,
    output logic                      M_AXI_RREADY
);
    localparam int IDX_W = $clog2(NUM_TXN + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TXN - 1);

    state_e                  state_q, state_d;
    mode_e                   mode_q, mode_d;
    logic [DATA_WIDTH-1:0]   seed_q, seed_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    init_q, init_d;
    logic                    awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
    logic                    bready_q, bready_d, rready_q, rready_d;
    logic                    error_q, error_d;
    logic [ERR_W-1:0]        err_cnt_q, err_cnt_d;

    logic                    start, err_inc, wd_expired, wd_enable, any_hs;
    logic                    aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [DATA_WIDTH-1:0]   pat;
    logic [ADDR_WIDTH-1:0]   addr;

    assign aw_hs  = awvalid_q & M_AXI_AWREADY;
    assign w_hs   = wvalid_q & M_AXI_WREADY;
    assign b_hs   = bready_q & M_AXI_BVALID;
    assign ar_hs  = arvalid_q & M_AXI_ARREADY;
    assign r_hs   = rready_q & M_AXI_RVALID;
    assign any_hs = aw_hs | w_hs | b_hs | ar_hs | r_hs;
    assign start  = INIT_AXI_TXN & ~init_q;

    assign pat  = DATA_WIDTH'(pattern(mode_q, 64'(seed_q), 32'(idx_q), DATA_WIDTH));
    assign addr = BASE_ADDR + ADDR_WIDTH'(idx_q) * ADDR_WIDTH'(DATA_WIDTH / 8);
    assign wd_enable = (state_q == S_WR_ADDR_DATA) || (state_q == S_WR_RESP) ||
                       (state_q == S_RD_ADDR) || (state_q == S_RD_DATA);

    axi_lite_tc_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (ACLK),
        .rst     (ARESET),
        .enable  (wd_enable),
        .clear   (any_hs),
        .expired (wd_expired)
    );

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        seed_d    = seed_q;
        idx_d     = idx_q;
        init_d    = INIT_AXI_TXN;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        bready_d  = bready_q;
        rready_d  = rready_q;
        error_d   = error_q;
        err_cnt_d = err_cnt_q;
        err_inc   = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_WR_ADDR_DATA;
                    mode_d    = mode_e'(MODE);
                    seed_d    = SEED;
                    idx_d     = '0;
                    error_d   = 1'b0;
                    err_cnt_d = '0;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                end
            end
            S_WR_ADDR_DATA: begin
                if (aw_hs) awvalid_d = 1'b0;
                if (w_hs)  wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = S_WR_RESP;
                    bready_d = 1'b1;
                end else if (wd_expired) begin
                    err_inc  = 1'b1;
                    bready_d = 1'b1;
                    state_d  = S_DRAIN;
                end
            end
            S_WR_RESP: begin
                if (b_hs) begin
                    bready_d = 1'b0;
                    if (M_AXI_BRESP != RESP_OKAY) err_inc = 1'b1;
                    if (idx_q != LAST_IDX) begin
                        idx_d     = idx_q + IDX_W'(1);
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = S_WR_ADDR_DATA;
                    end else if (mode_q == MODE_WRONLY) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d     = '0;
                        arvalid_d = 1'b1;
                        state_d   = S_RD_ADDR;
                    end
                end else if (wd_expired) begin
                    err_inc = 1'b1;
                    state_d = S_DRAIN;
                end
            end
            S_RD_ADDR: begin
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RD_DATA;
                end else if (wd_expired) begin
                    err_inc  = 1'b1;
                    rready_d = 1'b1;
                    state_d  = S_DRAIN;
                end
            end
            S_RD_DATA: begin
                if (r_hs) begin
                    rready_d = 1'b0;
                    if (M_AXI_RDATA != pat || M_AXI_RRESP != RESP_OKAY) err_inc = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d     = idx_q + IDX_W'(1);
                        arvalid_d = 1'b1;
                        state_d   = S_RD_ADDR;
                    end
                end else if (wd_expired) begin
                    err_inc = 1'b1;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Pending VALIDs stay up and owed responses are accepted before finishing.
                if (aw_hs) awvalid_d = 1'b0;
                if (w_hs)  wvalid_d  = 1'b0;
                if (ar_hs) arvalid_d = 1'b0;
                if (b_hs)  bready_d  = 1'b0;
                if (r_hs)  rready_d  = 1'b0;
                if (!(awvalid_d || wvalid_d || arvalid_d || bready_d || rready_d)) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (err_inc) begin
            error_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= S_IDLE;
            mode_q    <= MODE_INCR;
            seed_q    <= '0;
            idx_q     <= '0;
            init_q    <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            bready_q  <= 1'b0;
            rready_q  <= 1'b0;
            error_q   <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            seed_q    <= seed_d;
            idx_q     <= idx_d;
            init_q    <= init_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            bready_q  <= bready_d;
            rready_q  <= rready_d;
            error_q   <= error_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign TXN_DONE      = (state_q == S_DONE);
    assign BUSY          = (state_q != S_IDLE) && (state_q != S_DONE);
    assign ERROR         = error_q;
    assign ERR_CNT       = err_cnt_q;
    assign M_AXI_AWADDR  = addr;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = pat;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = addr;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;
endmodule

// File: tb/tb_axi_lite_traffic_checker.sv
// tb/tb_axi_lite_traffic_checker.sv - directed bench with a small AXI-Lite slave memory model
module tb_axi_lite_traffic_checker;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          ACLK = 1'b0;
    logic          ARESET = 1'b1;
    logic          INIT_AXI_TXN = 1'b0;
    logic [1:0]    MODE = 2'b00;
    logic [DW-1:0] SEED = '0;
    logic          TXN_DONE, ERROR, BUSY;
    logic [7:0]    ERR_CNT;
    logic [AW-1:0] M_AXI_AWADDR, M_AXI_ARADDR;
    logic [2:0]    M_AXI_AWPROT, M_AXI_ARPROT;
    logic          M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic [DW-1:0] M_AXI_WDATA, M_AXI_RDATA;
    logic [3:0]    M_AXI_WSTRB;
    logic [1:0]    M_AXI_BRESP, M_AXI_RRESP;
    logic          M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic          M_AXI_RVALID, M_AXI_RREADY;

    always #5 ACLK = ~ACLK;

    axi_lite_traffic_checker #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_TXN(4), .BASE_ADDR('0), .TIMEOUT(256), .ERR_W(8)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET), .INIT_AXI_TXN(INIT_AXI_TXN), .MODE(MODE), .SEED(SEED),
        .TXN_DONE(TXN_DONE), .ERROR(ERROR), .ERR_CNT(ERR_CNT), .BUSY(BUSY),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWVALID(M_AXI_AWVALID),
        .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP),
        .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR),
        .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
        .M_AXI_RREADY(M_AXI_RREADY)
    );

    // Slave memory model with fault-injection knobs keyed by word index.
    logic          aw_block = 1'b0;
    int            corrupt_beat = -1;
    int            bresp_err_beat = -1;
    int            aw_cnt = 0, ar_cnt = 0;
    logic [31:0]   mem [0:15];
    logic          aw_got = 1'b0, w_got = 1'b0, bvalid_s = 1'b0, rvalid_s = 1'b0;
    logic [AW-1:0] aw_addr_s = '0;
    logic [DW-1:0] w_data_s = '0, rdata_s = '0;
    logic [1:0]    bresp_s = 2'b00;
    logic          aw_fire, w_fire, ag_n, wg_n;
    logic [AW-1:0] aa_n;
    logic [DW-1:0] wd_n;

    assign M_AXI_AWREADY = ~aw_block;
    assign M_AXI_WREADY  = 1'b1;
    assign M_AXI_ARREADY = 1'b1;
    assign M_AXI_BVALID  = bvalid_s;
    assign M_AXI_BRESP   = bresp_s;
    assign M_AXI_RVALID  = rvalid_s;
    assign M_AXI_RDATA   = rdata_s;
    assign M_AXI_RRESP   = 2'b00;
    assign aw_fire = M_AXI_AWVALID & M_AXI_AWREADY;
    assign w_fire  = M_AXI_WVALID & M_AXI_WREADY;
    assign ag_n    = aw_got | aw_fire;
    assign wg_n    = w_got | w_fire;
    assign aa_n    = aw_fire ? M_AXI_AWADDR : aw_addr_s;
    assign wd_n    = w_fire ? M_AXI_WDATA : w_data_s;

    always @(posedge ACLK) begin
        if (ARESET) begin
            aw_got <= 1'b0; w_got <= 1'b0; bvalid_s <= 1'b0; rvalid_s <= 1'b0;
        end else begin
            if (aw_fire) aw_cnt <= aw_cnt + 1;
            aw_addr_s <= aa_n;
            w_data_s  <= wd_n;
            if (bvalid_s && M_AXI_BREADY) bvalid_s <= 1'b0;
            if (ag_n && wg_n) begin
                mem[aa_n[5:2]] <= wd_n;
                bvalid_s <= 1'b1;
                bresp_s  <= (bresp_err_beat == int'(aa_n[5:2])) ? 2'b10 : 2'b00;
                aw_got   <= 1'b0;
                w_got    <= 1'b0;
            end else begin
                aw_got <= ag_n;
                w_got  <= wg_n;
            end
            if (rvalid_s && M_AXI_RREADY) rvalid_s <= 1'b0;
            if (M_AXI_ARVALID && M_AXI_ARREADY) begin
                rvalid_s <= 1'b1;
                rdata_s  <= mem[M_AXI_ARADDR[5:2]] ^
                            ((corrupt_beat == int'(M_AXI_ARADDR[5:2])) ? 32'h0000_00FF : 32'h0);
                ar_cnt   <= ar_cnt + 1;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    task automatic start_run(input logic [1:0] m, input logic [31:0] s);
        MODE = m;
        SEED = s;
        INIT_AXI_TXN = 1'b1;
        tick(1);
        INIT_AXI_TXN = 1'b0;
        check("busy_after_start", BUSY, 1);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !TXN_DONE; i++) tick(1);
        check("done_in_budget", TXN_DONE, 1);
    endtask

    int aw0, ar0, k;

    initial begin
        tick(3);
        check("rst_valid_ready", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY}, 0);
        check("rst_flags", {TXN_DONE, ERROR, BUSY}, 0);
        check("rst_err_cnt", ERR_CNT, 0);
        ARESET = 1'b0;
        tick(2);

        // Incrementing pattern, clean run
        aw0 = aw_cnt; ar0 = ar_cnt;
        start_run(2'b00, 32'h1000_0000);
        check("t1_wstrb", M_AXI_WSTRB, 4'hF);
        check("t1_prot", {M_AXI_AWPROT, M_AXI_ARPROT}, 0);
        wait_done(200);
        check("t1_mem0", mem[0], 32'h1000_0000);
        check("t1_mem3", mem[3], 32'h1000_0003);
        check("t1_last_awaddr", aw_addr_s, 32'h0000_000C);
        check("t1_flags", {TXN_DONE, BUSY, ERROR}, 3'b100);
        check("t1_err_cnt", ERR_CNT, 0);
        check("t1_aw_count", aw_cnt - aw0, 4);
        check("t1_ar_count", ar_cnt - ar0, 4);

        // Inverted pattern, restarted from DONE
        start_run(2'b01, 32'h0);
        wait_done(200);
        check("t1b_mem1", mem[1], 32'hFFFF_FFFE);
        check("t1b_mem3", mem[3], 32'hFFFF_FFFC);
        check("t1b_error", {ERROR, ERR_CNT}, 0);

        // Walking one rotated by 30 wraps past bit 31
        start_run(2'b10, 32'h0000_001E);
        wait_done(200);
        check("t1c_mem0", mem[0], 32'h4000_0000);
        check("t1c_mem1", mem[1], 32'h8000_0000);
        check("t1c_mem2", mem[2], 32'h0000_0001);
        check("t1c_mem3", mem[3], 32'h0000_0002);
        check("t1c_error", {ERROR, ERR_CNT}, 0);

        // Seed+i wraps modulo 2^32
        start_run(2'b00, 32'hFFFF_FFFE);
        wait_done(200);
        check("wrap_mem2", mem[2], 32'h0);
        check("wrap_mem3", mem[3], 32'h1);
        check("wrap_error", {ERROR, ERR_CNT}, 0);

        // Corrupted read beat 2
        corrupt_beat = 2;
        ar0 = ar_cnt;
        start_run(2'b00, 32'h0000_00A0);
        wait_done(200);
        check("t2_error", ERROR, 1);
        check("t2_err_cnt", ERR_CNT, 1);
        check("t2_ar_count", ar_cnt - ar0, 4);
        corrupt_beat = -1;

        // SLVERR on write beat 0, write-only mode
        bresp_err_beat = 0;
        aw0 = aw_cnt; ar0 = ar_cnt;
        start_run(2'b11, 32'h0000_0077);
        wait_done(200);
        check("t3_error", ERROR, 1);
        check("t3_err_cnt", ERR_CNT, 1);
        check("t3_ar_count", ar_cnt - ar0, 0);
        check("t3_aw_count", aw_cnt - aw0, 4);
        bresp_err_beat = -1;

        // AWREADY held low past the watchdog limit
        aw_block = 1'b1;
        aw0 = aw_cnt;
        start_run(2'b00, 32'h0000_0300);
        for (int i = 0; i < 10 && M_AXI_WVALID; i++) tick(1);
        k = 0;
        while (!ERROR && k < 400) begin
            tick(1);
            k++;
        end
        check("t4_timeout_cycle", k, 256);
        check("t4_awvalid_held", M_AXI_AWVALID, 1);
        check("t4_busy_in_drain", BUSY, 1);
        tick(44);
        aw_block = 1'b0;
        wait_done(50);
        check("t4_err", {ERROR, ERR_CNT}, {1'b1, 8'd1});
        check("t4_aw_count", aw_cnt - aw0, 1);
        check("t4_drained", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}, 0);

        // Reset pulse while in RD_DATA, then a fresh run
        start_run(2'b00, 32'h0000_5000);
        for (int i = 0; i < 100 && !M_AXI_RREADY; i++) tick(1);
        check("t5_in_rd_data", M_AXI_RREADY, 1);
        ARESET = 1'b1;
        tick(1);
        check("t5_rst_valid_ready", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY}, 0);
        check("t5_rst_flags", {TXN_DONE, ERROR, BUSY, ERR_CNT}, 0);
        ARESET = 1'b0;
        tick(1);
        start_run(2'b00, 32'h0000_0055);
        wait_done(200);
        check("t5_mem3", mem[3], 32'h0000_0058);
        check("t5_error", {ERROR, ERR_CNT}, 0);

        // INIT held high, then re-pulsed while busy: only one run
        aw0 = aw_cnt; ar0 = ar_cnt;
        MODE = 2'b00; SEED = 32'h0000_0600;
        INIT_AXI_TXN = 1'b1;
        tick(10);
        INIT_AXI_TXN = 1'b0;
        tick(1);
        INIT_AXI_TXN = 1'b1;
        check("t6_busy_at_repulse", BUSY, 1);
        tick(1);
        INIT_AXI_TXN = 1'b0;
        wait_done(100);
        tick(20);
        check("t6_aw_count", aw_cnt - aw0, 4);
        check("t6_ar_count", ar_cnt - ar0, 4);
        check("t6_still_done", {TXN_DONE, ERROR}, 2'b10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
